// File: rtl/f_backtrace.sv
// Back-pointer walker for the formant segmentation DP.
// Follows B(k,i) from (k_start,i_start) down to k=1, buffers each segment's
// frame span, then streams spans out in ascending k over valid/ready.
// B-table reads use the shared port with a fixed 2-cycle read latency, so a
// walk step is REQ -> WAIT -> CHECK.
module f_backtrace #(
  parameter int BIT_WIDTH = 32,
  parameter int I         = 160,
  parameter int FORMANTS  = 5,
  localparam int IW       = $clog2(I),
  localparam int KW       = $clog2(FORMANTS + 1)
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 start,
  input  logic [KW-1:0]        k_start,
  input  logic [IW-1:0]        i_start,
  output logic                 rd_en,
  output logic [KW-1:0]        rd_k,
  output logic [IW-1:0]        rd_i,
  input  logic [BIT_WIDTH-1:0] b_rdata,
  output logic                 seg_valid,
  input  logic                 seg_ready,
  output logic [KW-1:0]        seg_k,
  output logic [IW-1:0]        seg_start,
  output logic [IW-1:0]        seg_end,
  output logic                 busy,
  output logic                 done,
  output logic                 error
);

  // buffer sized to the full k index range so any k_cur value indexes safely
  localparam int NB = 1 << KW;
  localparam logic signed [BIT_WIDTH-1:0] ONE = 1;
  localparam logic signed [BIT_WIDTH-1:0] TWO = 2;

  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_WAIT, S_CHECK, S_EMIT, S_FINISH
  } state_t;

  state_t              state;
  logic [KW-1:0]       k_cur, k_tot, idx;
  logic [IW-1:0]       i_cur;
  logic [IW-1:0]       sb_start [NB];
  logic [IW-1:0]       sb_end   [NB];

  logic signed [BIT_WIDTH-1:0] j_s, j_lo, j_hi;
  logic                        j_in_range, j_is_root, k_bad;
  logic [KW-1:0]               idx_nxt;
  logic [IW-1:0]               j_idx;

  // back-pointer legality and start-argument checks
  always_comb begin
    j_s        = $signed(b_rdata);
    j_lo       = $signed({{(BIT_WIDTH-KW){1'b0}}, k_cur}) - TWO;
    j_hi       = $signed({{(BIT_WIDTH-IW){1'b0}}, i_cur}) - ONE;
    j_in_range = (j_s >= j_lo) && (j_s <= j_hi);
    j_is_root  = (j_s == '1);
    j_idx      = j_s[IW-1:0];
    idx_nxt    = idx + 1'b1;
    k_bad      = (k_start == '0) ||
                 (32'(k_start) > 32'(FORMANTS)) ||
                 (32'(k_start) > 32'(i_start) + 32'd1);
  end

  // walk / emit FSM with registered outputs
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state     <= S_IDLE;
      k_cur     <= '0;
      k_tot     <= '0;
      i_cur     <= '0;
      idx       <= '0;
      rd_en     <= 1'b0;
      rd_k      <= '0;
      rd_i      <= '0;
      seg_valid <= 1'b0;
      seg_k     <= '0;
      seg_start <= '0;
      seg_end   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            k_cur <= k_start;
            i_cur <= i_start;
            k_tot <= k_start;
            busy  <= 1'b1;
            if (k_bad) begin
              state <= S_FINISH;
              done  <= 1'b1;
              error <= 1'b1;
            end else begin
              state <= S_REQ;
              rd_en <= 1'b1;
              rd_k  <= k_start;
              rd_i  <= i_start;
            end
          end
        end
        S_REQ: begin
          rd_en <= 1'b0;
          state <= S_WAIT;
        end
        S_WAIT: state <= S_CHECK;
        S_CHECK: begin
          if (k_cur == KW'(1)) begin
            if (j_is_root) begin
              sb_start[1] <= '0;
              sb_end[1]   <= i_cur;
              idx         <= KW'(1);
              seg_valid   <= 1'b1;
              seg_k       <= KW'(1);
              seg_start   <= '0;
              seg_end     <= i_cur;
              state       <= S_EMIT;
            end else begin
              state <= S_FINISH;
              done  <= 1'b1;
              error <= 1'b1;
            end
          end else if (j_in_range) begin
            sb_start[k_cur] <= j_idx + IW'(1);
            sb_end[k_cur]   <= i_cur;
            i_cur           <= j_idx;
            k_cur           <= k_cur - 1'b1;
            rd_en           <= 1'b1;
            rd_k            <= k_cur - 1'b1;
            rd_i            <= j_idx;
            state           <= S_REQ;
          end else begin
            state <= S_FINISH;
            done  <= 1'b1;
            error <= 1'b1;
          end
        end
        S_EMIT: begin
          if (seg_ready) begin
            if (idx == k_tot) begin
              seg_valid <= 1'b0;
              done      <= 1'b1;
              state     <= S_FINISH;
            end else begin
              idx       <= idx_nxt;
              seg_k     <= idx_nxt;
              seg_start <= sb_start[idx_nxt];
              seg_end   <= sb_end[idx_nxt];
            end
          end
        end
        S_FINISH: begin
          done  <= 1'b0;
          error <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_f_backtrace.sv
// Directed bench for f_backtrace: B-table model with 2-cycle read latency,
// a negedge monitor logging reads / segment transfers / done pulses, and
// hand-computed expectations per traceback.
module tb_f_backtrace;
  localparam int KW = 3;
  localparam int IW = 8;

  logic          clk_in = 1'b0;
  logic          rst_in, start, seg_ready;
  logic [KW-1:0] k_start, rd_k, seg_k;
  logic [IW-1:0] i_start, rd_i, seg_start, seg_end;
  logic [31:0]   b_rdata, d1;
  logic          rd_en, seg_valid, busy, done, error;

  f_backtrace #(.BIT_WIDTH(32), .I(160), .FORMANTS(5)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .start(start), .k_start(k_start),
    .i_start(i_start), .rd_en(rd_en), .rd_k(rd_k), .rd_i(rd_i),
    .b_rdata(b_rdata), .seg_valid(seg_valid), .seg_ready(seg_ready),
    .seg_k(seg_k), .seg_start(seg_start), .seg_end(seg_end),
    .busy(busy), .done(done), .error(error)
  );

  always #5 clk_in = ~clk_in;

  // B-table contents for the current test
  int          tk [4];
  int          ti [4];
  logic [31:0] tv [4];
  int          ntab = 0;

  function automatic logic [31:0] lookup(input int k, input int i);
    for (int n = 0; n < ntab; n++)
      if (tk[n] == k && ti[n] == i) return tv[n];
    return 32'h7fff_0000;
  endfunction

  // read data appears two cycles after the rd_en cycle
  always @(posedge clk_in) begin
    d1      <= rd_en ? lookup(int'(rd_k), int'(rd_i)) : 32'h5a5a_5a5a;
    b_rdata <= d1;
  end

  int cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  // monitor logs (cumulative; tests snapshot base indices)
  logic [18:0] rdl [64];
  int          rdc [64];
  logic [18:0] sgl [64];
  int          svc [64];
  int          nrd = 0, nseg = 0, nsv = 0, ndone = 0;
  logic        lasterr = 1'b0, prev_sv = 1'b0;

  always @(negedge clk_in) begin
    if (rd_en && nrd < 64) begin
      rdl[nrd] = {8'd0, rd_k, rd_i};
      rdc[nrd] = cyc;
      nrd++;
    end
    if (seg_valid && !prev_sv && nsv < 64) begin
      svc[nsv] = cyc;
      nsv++;
    end
    prev_sv = seg_valid;
    if (seg_valid && seg_ready && nseg < 64) begin
      sgl[nseg] = {seg_k, seg_start, seg_end};
      nseg++;
    end
    if (done) begin
      ndone++;
      lasterr = error;
    end
  end

  int total = 0, bad = 0, t0 = 0;
  int rb, sb, vb, db;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] sg(input int k, input int s, input int e);
    logic [2:0] kk;
    logic [7:0] ss, ee;
    kk = k[2:0];
    ss = s[7:0];
    ee = e[7:0];
    return {13'd0, kk, ss, ee};
  endfunction

  function automatic logic [31:0] rdp(input int k, input int i);
    logic [2:0] kk;
    logic [7:0] ii;
    kk = k[2:0];
    ii = i[7:0];
    return {21'd0, kk, ii};
  endfunction

  task automatic settab(input int n, input int k0, input int i0, input int v0,
                        input int k1, input int i1, input int v1,
                        input int k2, input int i2, input int v2);
    ntab = n;
    tk[0] = k0; ti[0] = i0; tv[0] = v0;
    tk[1] = k1; ti[1] = i1; tv[1] = v1;
    tk[2] = k2; ti[2] = i2; tv[2] = v2;
  endtask

  task automatic snap();
    rb = nrd; sb = nseg; vb = nsv; db = ndone;
  endtask

  // start is high for exactly one sampled cycle; t0 is that cycle
  task automatic kick(input int k, input int i);
    @(posedge clk_in); #1;
    start = 1'b1; k_start = k[KW-1:0]; i_start = i[IW-1:0];
    @(negedge clk_in); t0 = cyc;
    @(posedge clk_in); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (ndone == db && n < 200) begin
      @(negedge clk_in); #1;
      n++;
    end
    chk({tag, "_done"}, ndone, db + 1);
    @(negedge clk_in);
    chk({tag, "_tail"}, {30'd0, busy, done}, 32'd0);
  endtask

  task automatic check_case2(input string tag);
    chk({tag, "_nrd"}, nrd - rb, 3);
    chk({tag, "_rd0"}, rdl[rb],     rdp(3, 20));
    chk({tag, "_rd1"}, rdl[rb + 1], rdp(2, 12));
    chk({tag, "_rd2"}, rdl[rb + 2], rdp(1, 4));
    chk({tag, "_nseg"}, nseg - sb, 3);
    chk({tag, "_seg1"}, sgl[sb],     sg(1, 0, 4));
    chk({tag, "_seg2"}, sgl[sb + 1], sg(2, 5, 12));
    chk({tag, "_seg3"}, sgl[sb + 2], sg(3, 13, 20));
    chk({tag, "_err"}, lasterr, 0);
  endtask

  task automatic case1(input string tag);
    settab(1, 1, 9, -1, 0, 0, 0, 0, 0, 0);
    snap();
    kick(1, 9);
    wait_done(tag);
    chk({tag, "_nrd"}, nrd - rb, 1);
    chk({tag, "_rd"}, rdl[rb], rdp(1, 9));
    chk({tag, "_rdlat"}, rdc[rb] - t0, 1);
    chk({tag, "_nseg"}, nseg - sb, 1);
    chk({tag, "_seg"}, sgl[sb], sg(1, 0, 9));
    chk({tag, "_svlat"}, svc[vb] - t0, 4);
    chk({tag, "_err"}, lasterr, 0);
  endtask

  initial begin
    int n;
    rst_in = 1'b1; start = 1'b0; seg_ready = 1'b1; k_start = '0; i_start = '0;
    repeat (3) @(posedge clk_in);
    @(negedge clk_in);
    chk("rst_ctl", {27'd0, rd_en, busy, seg_valid, done, error}, 32'd0);
    chk("rst_seg", {seg_k, seg_start, seg_end}, 32'd0);
    @(posedge clk_in); #1 rst_in = 1'b0;

    // 1: single segment
    case1("c1");

    // 2: three segments, read spacing and first-valid latency
    settab(3, 3, 20, 12, 2, 12, 4, 1, 4, -1);
    snap();
    kick(3, 20);
    wait_done("c2");
    check_case2("c2");
    chk("c2_rdlat1", rdc[rb + 1] - rdc[rb], 3);
    chk("c2_rdlat2", rdc[rb + 2] - rdc[rb + 1], 3);
    chk("c2_svlat", svc[vb] - t0, 10);

    // 3: consumer stalls while segment 2 is presented
    snap();
    kick(3, 20);
    n = 0;
    while (!(seg_valid && seg_k == 3'd1) && n < 100) begin
      @(negedge clk_in);
      n++;
    end
    chk("c3_reach", {31'd0, seg_valid}, 32'd1);
    @(posedge clk_in); #1 seg_ready = 1'b0;
    repeat (3) begin
      @(negedge clk_in);
      chk("c3_hold", {12'd0, seg_valid, seg_k, seg_start, seg_end}, {12'd0, 1'b1, sg(2, 5, 12)[18:0]});
    end
    @(posedge clk_in); #1 seg_ready = 1'b1;
    wait_done("c3");
    check_case2("c3");

    // 4: bad back-pointer at k=2 (j=12 > i_cur-1=11)
    settab(2, 3, 20, 12, 2, 12, 12, 0, 0, 0);
    snap();
    kick(3, 20);
    wait_done("c4");
    chk("c4_err", lasterr, 1);
    chk("c4_nrd", nrd - rb, 2);
    chk("c4_nseg", nseg - sb, 0);
    chk("c4_nsv", nsv - vb, 0);

    // 5: illegal start arguments, no reads issued
    snap(); kick(0, 9); wait_done("c5a");
    chk("c5a_err", lasterr, 1); chk("c5a_nrd", nrd - rb, 0);
    snap(); kick(6, 9); wait_done("c5b");
    chk("c5b_err", lasterr, 1); chk("c5b_nrd", nrd - rb, 0);
    snap(); kick(4, 2); wait_done("c5c");
    chk("c5c_err", lasterr, 1); chk("c5c_nrd", nrd - rb, 0);

    // 6a: reset during WAIT of case 2
    settab(3, 3, 20, 12, 2, 12, 4, 1, 4, -1);
    snap();
    kick(3, 20);
    @(posedge clk_in); #1 rst_in = 1'b1;
    @(posedge clk_in); #1;
    @(negedge clk_in);
    chk("c6_rst_ctl", {27'd0, rd_en, busy, seg_valid, done, error}, 32'd0);
    chk("c6_rst_rd", {rd_k, rd_i}, 32'd0);
    @(posedge clk_in); #1 rst_in = 1'b0;
    repeat (6) @(negedge clk_in);
    chk("c6_nodone", ndone, db);
    chk("c6_nseg", nseg - sb, 0);
    case1("c6r");

    // 6b: start pulsed while busy is ignored
    settab(3, 3, 20, 12, 2, 12, 4, 1, 4, -1);
    snap();
    kick(3, 20);
    @(posedge clk_in); #1;
    start = 1'b1; k_start = 3'd1; i_start = 8'd9;
    @(posedge clk_in); #1 start = 1'b0;
    wait_done("c6b");
    repeat (4) @(negedge clk_in);
    check_case2("c6b");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // hard cycle bound so the bench always terminates
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
